// File: rtl/des_key_sched_dir.sv
// Iterative DES key schedule: emits K1..K16 (encrypt) or K16..K1 (decrypt),
// one subkey per valid/ready handshake, from a single 64-bit key.
module des_key_sched_dir (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode,
  input  logic [63:0] key,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [3:0]  round,
  output logic        last,
  output logic        busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  // Tables use DES 1-based bit numbers; bit 1 is the MSB of the source vector.
  localparam logic [5:0] PC1_TAB [56] = '{
    6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
    6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
    6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
    6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
    6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
    6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
    6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
    6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
  };

  localparam logic [5:0] PC2_TAB [48] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
    6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
    6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
    6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = 56'd0;
    for (int i = 0; i < 56; i++) begin
      r[55-i] = k[6'd63 - PC1_TAB[i] + 6'd1];
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = 48'd0;
    for (int i = 0; i < 48; i++) begin
      r[47-i] = cd[6'd56 - PC2_TAB[i]];
    end
    return r;
  endfunction

  // Rounds 1, 2, 9 and 16 shift by one; all others by two.
  function automatic logic shift_is_one(input logic [4:0] r);
    case (r)
      5'd1, 5'd2, 5'd9, 5'd16: shift_is_one = 1'b1;
      default:                 shift_is_one = 1'b0;
    endcase
  endfunction

  function automatic logic [27:0] rot(input logic [27:0] x, input logic right, input logic one);
    case ({right, one})
      2'b01:   rot = {x[26:0], x[27]};
      2'b00:   rot = {x[25:0], x[27:26]};
      2'b11:   rot = {x[0], x[27:1]};
      2'b10:   rot = {x[1:0], x[27:2]};
      default: rot = x;
    endcase
  endfunction

  logic [0:0]  fsm_q, fsm_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        dir_q, dir_d;
  logic [55:0] pc1_cd;
  logic        one_step;

  assign pc1_cd = pc1(key);
  // Encrypt advances to round cnt+2; decrypt steps back from round 16-cnt.
  assign one_step = dir_q ? shift_is_one(5'd16 - {1'b0, cnt_q})
                          : shift_is_one({1'b0, cnt_q} + 5'd2);

  // Next-state: load on start in IDLE, rotate one round per handshake in RUN.
  always_comb begin
    fsm_d = fsm_q;
    c_d   = c_q;
    d_d   = d_q;
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (fsm_q == IDLE) begin
      if (start) begin
        fsm_d = RUN;
        cnt_d = 4'd0;
        dir_d = mode;
        if (mode) begin
          c_d = pc1_cd[55:28];
          d_d = pc1_cd[27:0];
        end else begin
          c_d = rot(pc1_cd[55:28], 1'b0, 1'b1);
          d_d = rot(pc1_cd[27:0], 1'b0, 1'b1);
        end
      end else begin
        fsm_d = IDLE;
      end
    end else begin
      if (subkey_ready) begin
        if (cnt_q == 4'd15) begin
          fsm_d = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
          c_d   = rot(c_q, dir_q, one_step);
          d_d   = rot(d_q, dir_q, one_step);
        end
      end else begin
        fsm_d = RUN;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= IDLE;
      c_q   <= 28'd0;
      d_q   <= 28'd0;
      cnt_q <= 4'd0;
      dir_q <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      c_q   <= c_d;
      d_q   <= d_d;
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end

  assign subkey       = pc2({c_q, d_q});
  assign subkey_valid = (fsm_q == RUN);
  assign busy         = (fsm_q == RUN);
  assign last         = (fsm_q == RUN) && (cnt_q == 4'd15);
  assign round        = dir_q ? (4'd15 - cnt_q) : cnt_q;

endmodule

// File: doc/des_key_sched_dir.md
# des_key_sched_dir

Iterative DES key-schedule generator that turns one 64-bit key into the sixteen 48-bit round subkeys, one per accepted handshake. It serves both directions: ascending order K1..K16 with left rotations for encryption, descending order K16..K1 with right rotations for decryption. It sits ahead of the round datapath, whose XOR output drives the S_Box_1..S_Box_8 lookups. The decrypt order is the reason the block exists; without it, decryption needs a 768-bit subkey buffer.

## Interface
Parameters: none. The DES schedule is fixed.

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to load `key` and begin a schedule. Honoured only in IDLE.
- mode  in  1  0 = encrypt order (K1..K16), 1 = decrypt order (K16..K1). Sampled with `start`.
- key  in  64  DES key. `key[63]` = DES bit 1. Parity bits 8,16,..,64 are ignored.
- subkey  out  48  current round key. `subkey[47]` = DES bit 1.
- subkey_valid  out  1  `subkey`, `round` and `last` are valid.
- subkey_ready  in  1  consumer accepts the current subkey when `subkey_valid & subkey_ready`.
- round  out  4  DES round index minus 1 of the presented subkey: 0 = K1 … 15 = K16.
- last  out  1  high with the 16th subkey of the schedule.
- busy  out  1  high from `start` acceptance until the last handshake completes.

## Operation
- State registers:
  - C, D: 28 bits each.
  - cnt: 4 bits, steps issued.
  - dir: latched `mode`.
  - fsm: IDLE / RUN.
- `subkey` is pure PC-2 wiring of the C/D registers. No extra register.
- Shift amounts, indexed by DES round r = 1..16: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. The total is 28, so C/D return to their PC-1 value after a full schedule.
- Start acceptance (IDLE & `start`):
  - Encrypt (`mode`=0): C/D ← PC-1(key) rotated left 1, giving the K1 state.
  - Decrypt (`mode`=1): C/D ← PC-1(key) unrotated, giving the K16 state.
  - Both: cnt ← 0; fsm ← RUN.
- RUN, on each handshake with cnt < 15:
  - cnt ← cnt+1.
  - Encrypt: rotate C and D left by shift[cnt+2].
  - Decrypt: rotate C and D right by shift[16-cnt].
- RUN, on the handshake with cnt = 15: fsm ← IDLE; C/D keep their value.
- Output mapping:
  - `round` = cnt in encrypt mode, 15-cnt in decrypt mode.
  - `last` = RUN & (cnt == 15).
  - `subkey_valid` = `busy` = (fsm == RUN).
- No handshake (`subkey_ready` low): all state holds and outputs stay stable.
- `start` while in RUN is ignored. `key` and `mode` may change freely after acceptance.

## Timing
- Reset values:
  - fsm = IDLE; C = D = 0; cnt = 0.
  - Outputs: `subkey` = 0, `subkey_valid` = 0, `round` = 0, `last` = 0, `busy` = 0.
- `rst` mid-schedule overrides everything. The next cycle matches the reset values and the remaining subkeys are discarded.
- Latency: with `start` accepted at edge N, the first subkey is valid after edge N (visible in cycle N+1).
- Throughput: one subkey per cycle with `subkey_ready` tied high. A 16-key schedule spans exactly 16 valid cycles.
- End of schedule: after the last handshake, `subkey_valid` drops the next cycle.
  - A `start` asserted in that final RUN cycle is ignored.
  - The earliest new `start` is accepted in the first IDLE cycle. The gap between schedules is therefore one cycle.
- Wrap-around: cnt never exceeds 15. Rotations are modulo 28 within C and within D independently, with no mixing between halves.

## Test plan
- Key 0x133457799BBCDFF1, mode 0, ready high → subkeys 0x1B02EFFC7072 (round 0), 0x79AED9DBC9E5 (round 1) … 0xCB3D8B0E17F5 (round 15, `last`=1); then `subkey_valid` low.
- Same key, mode 1 → first subkey 0xCB3D8B0E17F5 with round 15; second 0xBF918D3D3F0A (round 14); final 0x1B02EFFC7072 with round 0 and `last`=1. The sequence is the exact reverse of the encrypt run.
- Backpressure: mode 1, `subkey_ready` random about 40% → subkey/round stable while stalled. Exactly 16 handshakes occur, matching the model order.
- `start` pulses during RUN, including the `last` cycle, with a different key → ignored; the schedule completes unchanged. A `start` in the following IDLE cycle loads the new key.
- `rst` asserted after 7 handshakes → next cycle all outputs are at reset values. A fresh `start` produces the full schedule from K1 (mode 0).
- Key 0x0000000000000000 and key 0x0101010101010101 (parity bits only) → all 16 subkeys are 0 in both modes.
